// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, frame size and the bit-period
// derivation that keeps uart_tx and uart_rx on the same cycle count.
package uart_pkg;

    localparam int DATA_BITS = 8;

    localparam logic [1:0] STATE_IDLE  = 2'b00;
    localparam logic [1:0] STATE_START = 2'b01;
    localparam logic [1:0] STATE_DATA  = 2'b10;
    localparam logic [1:0] STATE_STOP  = 2'b11;

    function automatic int cyc_count(input int system_clock, input int baud_rate);
        return system_clock / baud_rate;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; resets to all ones so an
// idle-high line does not produce a spurious edge out of reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: falling-edge start detection, mid-bit sampling, one-cycle
// valid / frame_err strobes at the stop-bit decision.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYSTEM_CLOCK = 32000000,
    parameter int BAUD_RATE    = 9600
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy,
    output logic [1:0]           state_out_dbg
);

    localparam int CYC_COUNT  = cyc_count(SYSTEM_CLOCK, BAUD_RATE);
    localparam int HALF_COUNT = CYC_COUNT / 2;
    localparam int CNT_W      = $clog2(CYC_COUNT) + 1;
    localparam int IDX_W      = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(CYC_COUNT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_COUNT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 rx_d_q;
    logic                 fall;

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (rx),
        .q_o    (rx_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_d_q <= 1'b1;
        end else begin
            rx_d_q <= rx_s;
        end
    end

    // Only a high-to-low transition starts a frame; a line held low stays idle.
    assign fall = rx_d_q & ~rx_s;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            STATE_IDLE: begin
                if (fall) begin
                    cnt_d   = '0;
                    state_d = STATE_START;
                end
            end
            STATE_START: begin
                if (cnt_q == HALF_LAST) begin
                    // Line back high at mid-start means it was a glitch.
                    if (!rx_s) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = STATE_DATA;
                    end else begin
                        state_d = STATE_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STATE_DATA: begin
                if (cnt_q == CYC_LAST) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    cnt_d   = '0;
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = STATE_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STATE_STOP: begin
                if (cnt_q == CYC_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    state_d = STATE_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= STATE_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data_out      = data_q;
    assign valid         = valid_q;
    assign frame_err     = ferr_q;
    assign busy          = (state_q != STATE_IDLE);
    assign state_out_dbg = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: clean frames, glitch,
// framing error with held-low line, back-to-back frames and mid-frame reset.
module tb_uart_rx;

    localparam int BIT_CYC = 16;
    localparam int STOP_LAT = 155;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_err;
    logic       busy;
    logic [1:0] state_out_dbg;

    int n_vec;
    int n_err;

    int cyc;
    int valid_cnt;
    int ferr_cnt;
    int both_cnt;
    int busy_cnt;
    int last_valid_cyc;
    int last_ferr_cyc;
    int t_start;

    uart_rx #(
        .SYSTEM_CLOCK (160),
        .BAUD_RATE    (10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .data_out      (data_out),
        .valid         (valid),
        .frame_err     (frame_err),
        .busy          (busy),
        .state_out_dbg (state_out_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        valid_cnt = 0; ferr_cnt = 0; both_cnt = 0; busy_cnt = 0;
        last_valid_cyc = 0; last_ferr_cyc = 0;
    end

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cyc;
        end
        if (frame_err === 1'b1) begin
            ferr_cnt      <= ferr_cnt + 1;
            last_ferr_cyc <= cyc;
        end
        if (valid === 1'b1 && frame_err === 1'b1) both_cnt <= both_cnt + 1;
        if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    end

    task automatic drive_bits(input logic b, input int n);
        rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        t_start = cyc;
        drive_bits(1'b0, BIT_CYC);
        for (int i = 0; i < 8; i++) drive_bits(d[i], BIT_CYC);
        drive_bits(stop_bit, BIT_CYC);
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", valid); end
        n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL rst_ferr got %b want 0", frame_err); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
        n_vec++; if (state_out_dbg !== 2'b00) begin n_err++; $display("FAIL rst_state got %b want 00", state_out_dbg); end
        n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL rst_data got %h want 00", data_out); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (100) @(negedge clk);
        n_vec++; if (valid_cnt !== 0 || ferr_cnt !== 0) begin
            n_err++; $display("FAIL idle_strobes got valid=%0d ferr=%0d want 0/0", valid_cnt, ferr_cnt);
        end
        n_vec++; if (busy_cnt !== 0) begin n_err++; $display("FAIL idle_busy got %0d busy cycles want 0", busy_cnt); end
        n_vec++; if (state_out_dbg !== 2'b00) begin n_err++; $display("FAIL idle_state got %b want 00", state_out_dbg); end
        n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL idle_data got %h want 00", data_out); end
    endtask

    task automatic test_frame(input logic [7:0] d);
        int v0, f0;
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(d, 1'b1);
        repeat (20) @(negedge clk);
        n_vec++; if (valid_cnt - v0 !== 1) begin
            n_err++; $display("FAIL frame_%h_valid got %0d pulses want 1", d, valid_cnt - v0);
        end
        n_vec++; if (ferr_cnt - f0 !== 0) begin
            n_err++; $display("FAIL frame_%h_ferr got %0d pulses want 0", d, ferr_cnt - f0);
        end
        n_vec++; if (data_out !== d) begin n_err++; $display("FAIL frame_%h_data got %h want %h", d, data_out, d); end
        n_vec++; if (last_valid_cyc - t_start !== STOP_LAT) begin
            n_err++; $display("FAIL frame_%h_latency got %0d want %0d", d, last_valid_cyc - t_start, STOP_LAT);
        end
    endtask

    task automatic test_glitch();
        int v0, f0;
        v0 = valid_cnt; f0 = ferr_cnt;
        drive_bits(1'b0, 4);
        n_vec++; if (state_out_dbg !== 2'b01) begin n_err++; $display("FAIL glitch_start got %b want 01", state_out_dbg); end
        drive_bits(1'b1, 16);
        n_vec++; if (state_out_dbg !== 2'b00) begin n_err++; $display("FAIL glitch_idle got %b want 00", state_out_dbg); end
        n_vec++; if (valid_cnt - v0 !== 0 || ferr_cnt - f0 !== 0) begin
            n_err++; $display("FAIL glitch_strobes got valid=%0d ferr=%0d want 0/0", valid_cnt - v0, ferr_cnt - f0);
        end
        n_vec++; if (data_out !== 8'hA3) begin n_err++; $display("FAIL glitch_data got %h want a3", data_out); end
    endtask

    task automatic test_frame_err();
        int v0, f0, b0;
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (10) @(negedge clk);
        b0 = busy_cnt;
        repeat (190) @(negedge clk);
        n_vec++; if (ferr_cnt - f0 !== 1) begin n_err++; $display("FAIL ferr_pulses got %0d want 1", ferr_cnt - f0); end
        n_vec++; if (valid_cnt - v0 !== 0) begin n_err++; $display("FAIL ferr_valid got %0d want 0", valid_cnt - v0); end
        n_vec++; if (data_out !== 8'hA3) begin n_err++; $display("FAIL ferr_data got %h want a3", data_out); end
        n_vec++; if (last_ferr_cyc - t_start !== STOP_LAT) begin
            n_err++; $display("FAIL ferr_latency got %0d want %0d", last_ferr_cyc - t_start, STOP_LAT);
        end
        n_vec++; if (busy_cnt - b0 !== 0 || state_out_dbg !== 2'b00) begin
            n_err++; $display("FAIL held_low got busy=%0d state=%b want 0/00", busy_cnt - b0, state_out_dbg);
        end
        drive_bits(1'b1, 20);
        test_frame(8'h5A);
    endtask

    task automatic test_back_to_back();
        int v0;
        v0 = valid_cnt;
        send_frame(8'h01, 1'b1);
        n_vec++; if (data_out !== 8'h01) begin n_err++; $display("FAIL b2b_first got %h want 01", data_out); end
        send_frame(8'hFF, 1'b1);
        repeat (20) @(negedge clk);
        n_vec++; if (valid_cnt - v0 !== 2) begin n_err++; $display("FAIL b2b_pulses got %0d want 2", valid_cnt - v0); end
        n_vec++; if (data_out !== 8'hFF) begin n_err++; $display("FAIL b2b_second got %h want ff", data_out); end
        n_vec++; if (last_valid_cyc - t_start !== STOP_LAT) begin
            n_err++; $display("FAIL b2b_latency got %0d want %0d", last_valid_cyc - t_start, STOP_LAT);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        int v0, f0;
        d = 8'h81;
        v0 = valid_cnt; f0 = ferr_cnt;
        drive_bits(1'b0, BIT_CYC);
        for (int i = 0; i < 4; i++) drive_bits(d[i], BIT_CYC);
        drive_bits(d[4], 8);
        n_vec++; if (state_out_dbg !== 2'b10) begin n_err++; $display("FAIL mid_in_data got %b want 10", state_out_dbg); end
        #2 rst = 1'b0;
        #1;
        n_vec++; if (state_out_dbg !== 2'b00 || busy !== 1'b0) begin
            n_err++; $display("FAIL mid_abort got state=%b busy=%b want 00/0", state_out_dbg, busy);
        end
        n_vec++; if (data_out !== 8'h00 || valid !== 1'b0 || frame_err !== 1'b0) begin
            n_err++; $display("FAIL mid_outputs got data=%h valid=%b ferr=%b want 00/0/0", data_out, valid, frame_err);
        end
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        n_vec++; if (valid_cnt - v0 !== 0 || ferr_cnt - f0 !== 0 || state_out_dbg !== 2'b00) begin
            n_err++; $display("FAIL mid_quiet got valid=%0d ferr=%0d state=%b want 0/0/00",
                              valid_cnt - v0, ferr_cnt - f0, state_out_dbg);
        end
        test_frame(8'h81);
    endtask

    initial begin
        n_vec = 0; n_err = 0; t_start = 0;
        rst = 1'b1;
        rx  = 1'b1;
        test_reset();
        test_frame(8'h55);
        test_frame(8'hA3);
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        n_vec++; if (both_cnt !== 0) begin n_err++; $display("FAIL valid_and_ferr got %0d overlap cycles want 0", both_cnt); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the serial-line consumer paired with the team's uart_tx.
- Synchronises the asynchronous rx line and detects the start bit from its falling edge.
- Samples each bit at mid-bit using the same SYSTEM_CLOCK/BAUD_RATE cycle counting as the transmitter.
- Presents each received byte with a one-cycle valid strobe. Flags framing errors.

Parameters:
SYSTEM_CLOCK  32000000  clock frequency in Hz
BAUD_RATE  9600  line rate in bit/s
CYC_COUNT  SYSTEM_CLOCK/BAUD_RATE  clock cycles per bit (3333 at defaults)
HALF_COUNT  CYC_COUNT/2  cycles from start-bit edge to mid-start-bit sample
CNT_W  $clog2(CYC_COUNT)+1  wait counter width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
rx  input  1  serial line; idle high; asynchronous to clk
data_out  output  8  last correctly framed byte; LSB received first
valid  output  1  one-cycle pulse: data_out updated this cycle
frame_err  output  1  one-cycle pulse: stop bit sampled low
busy  output  1  high in every state except IDLE
state_out_dbg  output  2  current state encoding

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; counter=0; bit index=0; shift register=0.
  - data_out=8'h00; valid=0; frame_err=0; busy=0.
  - Both synchroniser flops and the edge-history flop reset to 1.
- Input conditioning:
  - rx passes through a 2-flop synchroniser to give rx_s.
  - A further flop holds rx_d (rx_s delayed one cycle).
  - fall = rx_d & ~rx_s.
- State encoding: IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11.
- IDLE:
  - On fall: counter=0, go START. Otherwise stay.
  - A line held low does not retrigger; a new edge is required.
- START: counter increments each cycle. At counter==HALF_COUNT-1:
  - rx_s==0: counter=0, bit index=0, go DATA.
  - rx_s==1: glitch/false start; go IDLE with no strobe.
- DATA: counter increments each cycle. At counter==CYC_COUNT-1:
  - Shift rx_s into shift register MSB (right shift), so bit 0 ends in LSB.
  - counter=0; bit index+1.
  - After the 8th sample: go STOP.
- STOP: at counter==CYC_COUNT-1, sample rx_s.
  - 1: data_out=shift register, valid=1 for one cycle.
  - 0: frame_err=1 for one cycle; data_out unchanged.
  - Both cases: go IDLE on the same edge.
- Latency:
  - Stop sample falls ~HALF_COUNT+9*CYC_COUNT cycles after the synchronised falling edge.
  - valid is registered and rises on the cycle following the stop sample decision edge.
- valid and frame_err are never high together. Both are 0 in every cycle other than the stop-bit decision.
- Back-to-back frames: the next start edge may arrive half a bit after the stop sample and is accepted. The receiver is in IDLE by then.
- Reset mid-frame: immediate abort to reset values; no strobe. The next frame needs a fresh falling edge after reset release.
- Counter is compared with ==; width CNT_W guarantees no wrap before CYC_COUNT-1.

Decomposition:
- Shared package uart_pkg:
  - State encodings STATE_IDLE, STATE_START, STATE_DATA, STATE_STOP.
  - DATA_BITS=8.
  - The CYC_COUNT derivation, so uart_tx and uart_rx agree.
- One sub-module sync_2ff (parameterised width, async active-low reset, reset value 1). Reusable for other async inputs.

Test Plan:
Use SYSTEM_CLOCK=160, BAUD_RATE=10 (CYC_COUNT=16, HALF_COUNT=8).
- Reset, then rx idle high for 100 cycles -> valid=0, frame_err=0, busy=0, state_out_dbg=2'b00, data_out=8'h00.
- Drive frame 0x55 (bits 16 cycles each, stop=1) -> exactly one valid pulse, data_out=8'h55. Repeat with 0xA3 -> data_out=8'hA3.
- Low glitch of 4 cycles on idle line -> START entered, returns to IDLE at mid-start check; no valid, no frame_err.
- Frame 0x3C with stop bit driven 0 -> one frame_err pulse, valid=0, data_out keeps previous value. Line then held low 200 cycles -> no further activity until rx returns high and falls again.
- Two frames back-to-back (0x01 then 0xFF, no idle gap) -> two valid pulses, data_out 8'h01 then 8'hFF.
- Assert rst during DATA bit 4 of 0x81 -> outputs immediately at reset values. The following clean 0x81 frame -> valid, data_out=8'h81.
